// File: rtl/bcd_event_counter_pkg.sv
// Shared definitions for the BCD event counter: digit geometry, packed count
// type, per-cycle count action and debounce counter width.
package bcd_event_counter_pkg;

    localparam int unsigned DigitWidth = 4;
    localparam int unsigned NumDigits  = 3;
    localparam int unsigned CountWidth = DigitWidth * NumDigits;

    // Wide enough for the largest legal DB_CYCLES (2^24-1).
    localparam int unsigned DbCntWidth = 24;

    typedef logic [DigitWidth-1:0] bcd_digit_t;

    localparam bcd_digit_t DigitMax = 4'd9;

    // Index 2 = hundreds, 1 = tens, 0 = ones.
    typedef logic [NumDigits-1:0][DigitWidth-1:0] bcd_count_t;

    typedef enum logic [1:0] {
        ActHold,
        ActInc,
        ActDec,
        ActClr
    } count_act_e;

    // True when every digit of the count is a legal decimal digit.
    function automatic logic count_valid(input bcd_count_t count);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NumDigits; i++) begin
            if (count[i] > DigitMax) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_event_counter_btn_debounce.sv
// Push-button front end: two-flop synchronizer, optional stability filter and
// a registered one-cycle press pulse on the filtered 0->1 transition.
// The filter is built only when BCD_COUNTER_DEBOUNCE_EN is defined; otherwise
// the filtered level is the synchronized level and DB_CYCLES is unused.
module btn_debounce
    import bcd_event_counter_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic [1:0] r_sync;
    logic       w_level;
    logic       r_level_d;
    logic       r_press;

    // Bring the raw button into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

`ifdef BCD_COUNTER_DEBOUNCE_EN
    localparam logic [DbCntWidth-1:0] DbLast = DbCntWidth'(DB_CYCLES - 1);

    logic [DbCntWidth-1:0] r_cnt;
    logic                  r_filt;

    // Count consecutive cycles of disagreement; any agreement restarts at 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (r_sync[1] == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == DbLast) begin
            r_filt <= r_sync[1];
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[1];
`endif

    // Registered rising-edge detect on the filtered level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= w_level;
            r_press   <= w_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/bcd_event_counter.sv
// Three-digit BCD up/down counter driven by three debounced push-buttons.
// Clear wins over up/down; simultaneous up and down cancel. wrap pulses for
// one cycle on 999->000 or 000->999. Filtering is enabled by defining
// BCD_COUNTER_DEBOUNCE_EN (see btn_debounce).
module bcd_event_counter
    import bcd_event_counter_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_clr,
    output logic [CountWidth-1:0] decimals,
    output logic                  wrap
);

    logic           w_up_press;
    logic           w_down_press;
    logic           w_clr_press;

    bcd_count_t     r_count;
    logic           r_wrap;

    bcd_count_t     w_inc;
    bcd_count_t     w_dec;
    logic [NumDigits:0] w_carry;
    logic [NumDigits:0] w_borrow;
    count_act_e     w_act;
    bcd_count_t     w_next;
    logic           w_next_wrap;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_up (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_up),
        .o_press (w_up_press)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_down (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_down),
        .o_press (w_down_press)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_clr (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_clr),
        .o_press (w_clr_press)
    );

    // Ripple BCD increment and decrement; a digit at/above 9 folds to 0 on
    // increment so an illegal digit can never survive a count step.
    always_comb begin
        w_inc       = r_count;
        w_dec       = r_count;
        w_carry     = '0;
        w_borrow    = '0;
        w_carry[0]  = 1'b1;
        w_borrow[0] = 1'b1;
        for (int i = 0; i < NumDigits; i++) begin
            if (w_carry[i]) begin
                if (r_count[i] >= DigitMax) begin
                    w_inc[i]     = '0;
                    w_carry[i+1] = 1'b1;
                end else begin
                    w_inc[i] = r_count[i] + 4'd1;
                end
            end
            if (w_borrow[i]) begin
                if (r_count[i] == '0) begin
                    w_dec[i]      = DigitMax;
                    w_borrow[i+1] = 1'b1;
                end else if (r_count[i] > DigitMax) begin
                    w_dec[i] = DigitMax;
                end else begin
                    w_dec[i] = r_count[i] - 4'd1;
                end
            end
        end
    end

    // Decode this cycle's press pulses into a single action.
    always_comb begin
        w_act = ActHold;
        if (w_clr_press) begin
            w_act = ActClr;
        end else if (w_up_press && !w_down_press) begin
            w_act = ActInc;
        end else if (w_down_press && !w_up_press) begin
            w_act = ActDec;
        end
    end

    // Select next count and wrap flag from the decoded action.
    always_comb begin
        w_next      = r_count;
        w_next_wrap = 1'b0;
        unique case (w_act)
            ActInc: begin
                w_next      = w_inc;
                w_next_wrap = w_carry[NumDigits];
            end
            ActDec: begin
                w_next      = w_dec;
                w_next_wrap = w_borrow[NumDigits];
            end
            ActClr: begin
                w_next = '0;
            end
            default: begin
                w_next = r_count;
            end
        endcase
    end

    // Count and wrap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_next_wrap;
        end
    end

    assign decimals = r_count;
    assign wrap     = r_wrap;

    digits_valid_a : assert property (@(posedge clk) disable iff (!rst_n) count_valid(r_count));

endmodule

// File: tb/tb_bcd_event_counter.sv
// Scoreboard bench for bcd_event_counter with DB_CYCLES = 4.
module tb_bcd_event_counter;

    localparam int unsigned DB = 4;
`ifdef BCD_COUNTER_DEBOUNCE_EN
    localparam int unsigned LAT = 2 + DB + 1 + 1;
    localparam bit          DEB = 1'b1;
`else
    localparam int unsigned LAT = 4;
    localparam bit          DEB = 1'b0;
`endif
    localparam int unsigned HOLD = LAT + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_clr = 1'b0;
    logic [11:0] decimals;
    logic        wrap;

    always #5 clk = ~clk;

    bcd_event_counter #(
        .DB_CYCLES (DB)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_clr  (btn_clr),
        .decimals (decimals),
        .wrap     (wrap)
    );

    typedef struct {
        logic [11:0] val;
        logic        wrp;
        int          at;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          model = 0;
    int          wrap_seen = 0;
    logic [11:0] prev_dec = 12'h000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Compare every change of decimals against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_dec = decimals;
        end else begin
            if (wrap) wrap_seen++;
            if (decimals !== prev_dec) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_change", {20'h0, decimals}, {20'h0, prev_dec});
                end else begin
                    e = sb_q.pop_front();
                    check_eq("value", {20'h0, decimals}, {20'h0, e.val});
                    check_eq("wrap_with_value", {31'h0, wrap}, {31'h0, e.wrp});
                    check_eq("latency_cycle", cyc, e.at);
                end
                prev_dec = decimals;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Apply the reference behaviour for a press seen now; queue the result.
    task automatic expect_action(input bit u, input bit d, input bit c);
        int nv;
        bit w;
        nv = model;
        w  = 1'b0;
        if (c) begin
            nv = 0;
        end else if (u && !d) begin
            w  = (model == 999);
            nv = (model + 1) % 1000;
        end else if (d && !u) begin
            w  = (model == 0);
            nv = (model + 999) % 1000;
        end
        if (nv != model) sb_q.push_back('{to_bcd(nv), w, cyc + LAT});
        model = nv;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check_eq(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic press(input bit u, input bit d, input bit c);
        tick(1);
        btn_up   = u;
        btn_down = d;
        btn_clr  = c;
        expect_action(u, d, c);
        tick(HOLD);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_clr  = 1'b0;
        tick(HOLD);
        wait_drain("drain");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        tick(3);
        check_eq("reset_decimals", {20'h0, decimals}, 32'h0);
        check_eq("reset_wrap", {31'h0, wrap}, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Five clean up presses.
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0);
        check_eq("count_005", {20'h0, decimals}, 32'h005);
        check_eq("no_wrap_after_5", wrap_seen, 0);

        // Clear, then borrow through 000 -> 999 -> 998.
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        check_eq("wrap_down_once", wrap_seen, 1);
        press(1'b0, 1'b1, 1'b0);
        check_eq("count_998", {20'h0, decimals}, 32'h998);

        // Carry through 999 -> 000.
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check_eq("count_000_wrap", {20'h0, decimals}, 32'h000);
        check_eq("wrap_up_once", wrap_seen, 2);

        // Bouncing up button, then held.
        tick(1);
        btn_up = 1'b1;
        if (!DEB) expect_action(1'b1, 1'b0, 1'b0);
        tick(2);
        btn_up = 1'b0;
        tick(2);
        btn_up = 1'b1;
        if (!DEB) expect_action(1'b1, 1'b0, 1'b0);
        tick(2);
        btn_up = 1'b0;
        tick(2);
        btn_up = 1'b1;
        expect_action(1'b1, 1'b0, 1'b0);
        tick(10);
        btn_up = 1'b0;
        tick(HOLD);
        wait_drain("drain_bounce");
        check_eq("bounce_count", {20'h0, decimals}, {20'h0, to_bcd(model)});

        // Climb to 109 and test simultaneous events.
        press(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 109; i++) press(1'b1, 1'b0, 1'b0);
        check_eq("count_109", {20'h0, decimals}, 32'h109);
        press(1'b1, 1'b1, 1'b0);
        check_eq("up_down_cancel", {20'h0, decimals}, 32'h109);
        press(1'b1, 1'b0, 1'b1);
        check_eq("up_clr_clears", {20'h0, decimals}, 32'h000);
        check_eq("clr_no_wrap", wrap_seen, 2);

        // Reset mid-debounce at 047 with up held.
        for (int i = 0; i < 47; i++) press(1'b1, 1'b0, 1'b0);
        check_eq("count_047", {20'h0, decimals}, 32'h047);
        tick(1);
        btn_up = 1'b1;
        tick(3);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_decimals", {20'h0, decimals}, 32'h0);
        check_eq("async_reset_wrap", {31'h0, wrap}, 32'h0);
        model = 0;
        tick(3);
        rst_n = 1'b1;
        expect_action(1'b1, 1'b0, 1'b0);
        tick(HOLD + 4);
        btn_up = 1'b0;
        tick(HOLD);
        wait_drain("drain_after_reset");
        check_eq("held_through_reset", {20'h0, decimals}, 32'h001);
        check_eq("final_wrap_total", wrap_seen, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
